glitch_monitor: RTL

- Receive-side counterpart of the PWM glitch generator. Samples an external square wave on a board input pin, which may be looped back from the glitch output.
- Measures each high and low phase in clk cycles and locks onto the nominal half-period.
- Once locked, flags any phase whose width falls outside tolerance as a glitch and counts glitches. The count drives the board LEDs.

---
 rtl/glitch_monitor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/glitch_monitor.sv
// Square-wave phase-width monitor: locks onto the nominal half-period and
// counts phases whose width falls outside tolerance once locked.
module glitch_monitor #(
  parameter int HALF_PERIOD = 25,
  parameter int TOL         = 1,
  parameter int LOCK_EDGES  = 4,
  parameter int TIMEOUT     = 100,
  parameter int W           = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clear,
  output logic             locked,
  output logic             glitch,
  output logic             glitch_high,
  output logic [W-1:0]     last_width,
  output logic [CNT_W-1:0] glitch_count
);

  // state  | meaning
  // HUNT   | collecting consecutive in-tolerance phases, no glitch reporting
  // LOCKED | nominal period acquired, out-of-tolerance phases are glitches
  typedef enum logic {HUNT, LOCKED} state_t;

  localparam int GR_W = $clog2(LOCK_EDGES + 1);
  localparam logic [W-1:0]     W_LO    = W'(HALF_PERIOD - TOL);
  localparam logic [W-1:0]     W_HI    = W'(HALF_PERIOD + TOL);
  localparam logic [W-1:0]     W_TO    = W'(TIMEOUT);
  localparam logic [W-1:0]     W_MAX   = '1;
  localparam logic [GR_W-1:0]  GR_LAST = GR_W'(LOCK_EDGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1, s2, s3;
  state_t           state, state_n;
  logic [W-1:0]     w, w_n;
  logic             first, first_n;
  logic [GR_W-1:0]  good_run, good_run_n;
  logic             glitch_n, glitch_high_n;
  logic [W-1:0]     last_width_n;
  logic [CNT_W-1:0] glitch_count_n;
  logic             sig_edge, good, cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= HUNT;
      w            <= W'(1);
      first        <= 1'b1;
      good_run     <= '0;
      glitch       <= 1'b0;
      glitch_high  <= 1'b0;
      last_width   <= '0;
      glitch_count <= '0;
    end else begin
      s1           <= sig_in;
      s2           <= s1;
      s3           <= s2;
      state        <= state_n;
      w            <= w_n;
      first        <= first_n;
      good_run     <= good_run_n;
      glitch       <= glitch_n;
      glitch_high  <= glitch_high_n;
      last_width   <= last_width_n;
      glitch_count <= glitch_count_n;
    end
  end

  assign locked = (state == LOCKED);

  always_comb begin
    state_n       = state;
    first_n       = first;
    good_run_n    = good_run;
    glitch_n      = 1'b0;
    glitch_high_n = glitch_high;
    last_width_n  = last_width;
    cnt_inc       = 1'b0;

    sig_edge = s2 ^ s3;
    good     = (w >= W_LO) && (w <= W_HI);

    if (sig_edge)
      w_n = W'(1);
    else if (w == W_MAX)
      w_n = w;
    else
      w_n = w + W'(1);

    if (sig_edge) begin
      if (!first)
        last_width_n = w;
      case (state)
        HUNT: begin
          if (first)
            first_n = 1'b0;
          else if (good) begin
            if (good_run == GR_LAST) begin
              state_n    = LOCKED;
              good_run_n = '0;
            end else begin
              good_run_n = good_run + GR_W'(1);
            end
          end else begin
            good_run_n = '0;
          end
        end
        LOCKED: begin
          if (!good) begin
            glitch_n      = 1'b1;
            glitch_high_n = s3;
            cnt_inc       = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end else if (w_n == W_TO && w != W_TO) begin
      // No edge for TIMEOUT cycles: the input has stopped toggling.
      state_n    = HUNT;
      first_n    = 1'b1;
      good_run_n = '0;
    end

    if (clear)
      glitch_count_n = '0;
    else if (cnt_inc && glitch_count != CNT_MAX)
      glitch_count_n = glitch_count + CNT_W'(1);
    else
      glitch_count_n = glitch_count;
  end

endmodule
